// File: rtl/ap_caller_pkg.sv
// Shared types and defaults for the ap_ctrl_hs initiator.
// AP_CALLER_TIMEOUT_EN enables the call watchdog.
package ap_caller_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        START = 2'd1,
        WAIT  = 2'd2,
        RESP  = 2'd3
    } state_e;

    localparam int unsigned AP_DATA_W  = 32;
    localparam int unsigned AP_TIMEOUT = 1024;

endpackage

// File: rtl/ap_caller_watchdog.sv
// Cycle counter bounding a single outstanding call.
// Cleared on load, counts while enabled, flags the last allowed cycle.
module ap_caller_watchdog #(
    parameter int unsigned LIMIT = 1024
) (
    input  logic clk_i,
    input  logic rst_i,
    input  logic load_i,
    input  logic en_i,
    output logic expired_o
);

    localparam int unsigned W = $clog2(LIMIT) + 1;

    logic [W-1:0] cnt_q, cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (load_i) begin
            cnt_d = '0;
        end else if (en_i) begin
            cnt_d = cnt_q + W'(1);
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign expired_o = en_i && (cnt_q == W'(LIMIT - 1));

endmodule

// File: rtl/ap_hs_caller.sv
// Initiator side of the ap_ctrl_hs block handshake.
// Optional watchdog abort under AP_CALLER_TIMEOUT_EN.
module ap_hs_caller
    import ap_caller_pkg::*;
#(
    parameter int unsigned DATA_W         = AP_DATA_W,
    parameter int unsigned CNT_W          = 16,
    parameter int unsigned TIMEOUT_CYCLES = AP_TIMEOUT
) (
    input  logic              ap_clk,
    input  logic              ap_rst,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic [DATA_W-1:0] req_s,
    input  logic [DATA_W-1:0] req_e,
    output logic              rsp_valid,
    input  logic              rsp_ready,
    output logic [DATA_W-1:0] rsp_data,
    output logic              rsp_err,
    output logic              ap_start,
    input  logic              ap_done,
    input  logic              ap_idle,
    input  logic              ap_ready,
    output logic [DATA_W-1:0] s,
    output logic [DATA_W-1:0] e,
    input  logic [DATA_W-1:0] ap_return,
    output logic              busy,
    output logic [CNT_W-1:0]  calls_done
);

    state_e            state_q, state_d;
    logic [DATA_W-1:0] s_q, s_d;
    logic [DATA_W-1:0] e_q, e_d;
    logic [DATA_W-1:0] data_q, data_d;
    logic              err_q, err_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;

    logic req_fire;
    logic rsp_fire;
    logic in_call;
    logic wd_expired;

`ifdef AP_CALLER_TIMEOUT_EN
    ap_caller_watchdog #(
        .LIMIT(TIMEOUT_CYCLES)
    ) u_wd (
        .clk_i    (ap_clk),
        .rst_i    (ap_rst),
        .load_i   (req_fire),
        .en_i     (in_call),
        .expired_o(wd_expired)
    );
`else
    // No watchdog: a call waits for ap_done forever.
    assign wd_expired = 1'b0 && (TIMEOUT_CYCLES != 0);
`endif

    always_ff @(posedge ap_clk) begin
        if (ap_rst) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE: begin
                if (req_fire) state_d = START;
            end
            START: begin
                if (ap_done || wd_expired) begin
                    state_d = RESP;
                end else if (ap_ready) begin
                    state_d = WAIT;
                end
            end
            WAIT: begin
                if (ap_done || wd_expired) state_d = RESP;
            end
            RESP: begin
                if (rsp_ready) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        ap_start  = 1'b0;
        rsp_valid = 1'b0;
        req_ready = 1'b0;
        in_call   = 1'b0;
        unique case (state_q)
            IDLE:  req_ready = ap_idle & ~ap_rst;
            START: begin
                ap_start = 1'b1;
                in_call  = 1'b1;
            end
            WAIT:  in_call   = 1'b1;
            RESP:  rsp_valid = 1'b1;
            default: ;
        endcase
    end

    assign req_fire = req_valid & req_ready;
    assign rsp_fire = rsp_valid & rsp_ready;

    // ap_done beats a same-cycle watchdog expiry.
    always_comb begin
        s_d    = s_q;
        e_d    = e_q;
        data_d = data_q;
        err_d  = err_q;
        cnt_d  = cnt_q;
        if (req_fire) begin
            s_d = req_s;
            e_d = req_e;
        end
        if (in_call) begin
            if (ap_done) begin
                data_d = ap_return;
                err_d  = 1'b0;
            end else if (wd_expired) begin
                data_d = '0;
                err_d  = 1'b1;
            end
        end
        if (rsp_fire) cnt_d = cnt_q + CNT_W'(1);
    end

    always_ff @(posedge ap_clk) begin
        if (ap_rst) begin
            s_q    <= '0;
            e_q    <= '0;
            data_q <= '0;
            err_q  <= 1'b0;
            cnt_q  <= '0;
        end else begin
            s_q    <= s_d;
            e_q    <= e_d;
            data_q <= data_d;
            err_q  <= err_d;
            cnt_q  <= cnt_d;
        end
    end

    assign s          = s_q;
    assign e          = e_q;
    assign rsp_data   = data_q;
    assign rsp_err    = err_q;
    assign calls_done = cnt_q;
    assign busy       = (state_q != IDLE);

endmodule

// File: doc/ap_hs_caller.md
Name: ap_hs_caller

Overview:
- Initiator side of the ap_ctrl_hs block-level handshake used by the team's HLS-style cores (ap_start/ap_done/ap_idle/ap_ready, two 32-bit operands s, e, one 32-bit ap_return).
- Accepts an operand pair on a valid/ready request port and drives the callee's start and argument signals.
- Captures ap_return on ap_done and presents it on a valid/ready response port.
- Sits between a system bus or test sequencer and any core with that interface.

Parameters:
- DATA_W, 32, width of s, e, ap_return, req_s, req_e, rsp_data
- CNT_W, 16, width of the completed-call counter
- TIMEOUT_CYCLES, 1024, watchdog limit in cycles; used only with AP_CALLER_TIMEOUT_EN

Ports:
- ap_clk  in  1  clock, all logic rising-edge
- ap_rst  in  1  synchronous active-high reset, shared with callee
- req_valid  in  1  request operand pair valid
- req_ready  out  1  caller can accept a request
- req_s  in  DATA_W  operand s
- req_e  in  DATA_W  operand e
- rsp_valid  out  1  result valid
- rsp_ready  in  1  consumer accepts result
- rsp_data  out  DATA_W  captured ap_return
- rsp_err  out  1  call aborted by watchdog (0 when feature compiled out)
- ap_start  out  1  to callee
- ap_done  in  1  from callee
- ap_idle  in  1  from callee
- ap_ready  in  1  from callee
- s  out  DATA_W  to callee, registered
- e  out  DATA_W  to callee, registered
- ap_return  in  DATA_W  from callee, valid when ap_done=1
- busy  out  1  state != IDLE
- calls_done  out  CNT_W  count of completed calls, wraps

Behaviour:
- Reset:
  - state=IDLE.
  - Outputs: ap_start=0, rsp_valid=0, rsp_err=0, rsp_data=0, s=0, e=0, calls_done=0, busy=0.
  - Reset mid-call abandons the call with no response; ap_start is low the cycle after reset is sampled.
- States: IDLE, START, WAIT, RESP.
- IDLE:
  - req_ready = ap_idle.
  - On req_valid & req_ready: register s<=req_s, e<=req_e; next state START.
- START:
  - ap_start=1, held until a cycle with ap_ready=1 or ap_done=1.
  - ap_done=1 (with or without ap_ready): capture rsp_data<=ap_return, drop ap_start, go RESP.
  - ap_ready=1 without ap_done: drop ap_start next cycle, go WAIT.
- WAIT:
  - ap_start=0.
  - On ap_done=1: capture ap_return, go RESP.
- RESP:
  - rsp_valid=1; rsp_data and rsp_err stable until rsp_valid & rsp_ready.
  - On handshake: go IDLE and increment calls_done, mod 2^CNT_W. A watchdog abort still counts.
- s and e are held constant from START entry until the next accepted request.
- Callee's ap_start is never asserted outside START.
- ap_done, ap_ready or ap_return seen in IDLE or RESP are ignored.
- req_ready=0 in every state except IDLE; one call outstanding at a time.
- Latency:
  - req handshake to ap_start high: 1 cycle.
  - ap_done to rsp_valid: 1 cycle.
  - Zero-latency callee (ap_done in first START cycle): req→rsp_valid 2 cycles; minimum request period 3 cycles.

Optional Feature:
- Macro AP_CALLER_TIMEOUT_EN.
- Defined:
  - Watchdog counter cleared on START entry and incremented each cycle in START/WAIT.
  - If it reaches TIMEOUT_CYCLES-1 with no ap_done that cycle: drop ap_start, go RESP with rsp_err=1, rsp_data=0.
  - ap_done in the same cycle as expiry wins (normal completion, rsp_err=0).
- Not defined: no counter; WAIT/START last indefinitely; rsp_err tied 0.

Decomposition:
- Package ap_caller_pkg:
  - state enum (IDLE, START, WAIT, RESP)
  - default DATA_W
  - default timeout constant
- One sub-module, ap_caller_watchdog (load/enable/expired), instantiated only under AP_CALLER_TIMEOUT_EN; everything else lives in a single FSM.

Test Plan:
- Reset held 3 cycles while req_valid=1, then released → all outputs 0, ap_start stays 0 during reset, first request accepted 1 cycle after release.
- req s=5, e=9; callee asserts ap_ready+ap_done in first START cycle with ap_return=0x0000000E → ap_start high exactly 1 cycle; rsp_valid 2 cycles after request with rsp_data=0xE; calls_done=1 after rsp handshake.
- Callee: ap_ready after 4 cycles, ap_done 10 cycles later, ap_return=0xDEADBEEF; rsp_ready low 5 cycles → ap_start high 4 cycles; s/e stable throughout; rsp_data held at 0xDEADBEEF until accepted; req_ready low until then.
- Callee keeps ap_idle=0 → req_ready=0, no request accepted; ap_idle→1 → accepted same cycle.
- Stray ap_done pulse in IDLE and RESP → no state change, rsp_data unchanged, calls_done unchanged.
- With AP_CALLER_TIMEOUT_EN, TIMEOUT_CYCLES=8, callee never completes:
  - rsp_valid=1, rsp_err=1, rsp_data=0 after 8 cycles in START/WAIT.
  - Repeat with ap_done on the expiry cycle → rsp_err=0, rsp_data=ap_return.
